// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// instruction/offset widths and the default reset PC.
package inst_fetch_pkg;

   typedef enum logic {
      FETCH = 1'b0,
      ISSUE = 1'b1
   } fetch_state_e;

   localparam int INST_WIDTH       = 16;
   localparam int BR_OFS_WIDTH     = 8;
   localparam int DEFAULT_RESET_PC = 0;

endpackage

// File: rtl/inst_fetch_pc_target_calc.sv
// Combinational PC arithmetic: sequential increment and PC-relative branch
// target, both wrapping modulo 2^PC_WIDTH.
module pc_target_calc
   import inst_fetch_pkg::*;
#(
   parameter int PC_WIDTH = 8
) (
   input  logic [PC_WIDTH-1:0]     pc_i,
   input  logic [PC_WIDTH-1:0]     pc_out_i,
   input  logic [BR_OFS_WIDTH-1:0] offset_i,
   output logic [PC_WIDTH-1:0]     pc_inc_o,
   output logic [PC_WIDTH-1:0]     target_o
);

   logic [PC_WIDTH-1:0] ofsExt;

   // Signed cast sign-extends for wide PCs and truncates for narrow ones.
   assign ofsExt   = PC_WIDTH'($signed(offset_i));
   assign pc_inc_o = pc_i + PC_WIDTH'(1);
   assign target_o = pc_out_i + PC_WIDTH'(1) + ofsExt;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake and
// presents one instruction at a time to the decoder, with branch redirect.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int                 PC_WIDTH = 8,
   parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(DEFAULT_RESET_PC)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   output logic                    imem_req,
   output logic [PC_WIDTH-1:0]     imem_addr,
   input  logic [INST_WIDTH-1:0]   imem_rdata,
   input  logic                    imem_ack,
   input  logic                    stall,
   input  logic                    branch_taken,
   input  logic [BR_OFS_WIDTH-1:0] branch_offset,
   output logic [INST_WIDTH-1:0]   instruction,
   output logic                    inst_valid,
   output logic [PC_WIDTH-1:0]     pc_out
);

   fetch_state_e          state_q, state_d;
   logic [PC_WIDTH-1:0]   pc_q, pc_d;
   logic [PC_WIDTH-1:0]   pcOut_q, pcOut_d;
   logic [PC_WIDTH-1:0]   holdAddr_q, holdAddr_d;
   logic [INST_WIDTH-1:0] inst_q, inst_d;
   logic                  valid_q, valid_d;
   logic                  kill_q, kill_d;
   logic [PC_WIDTH-1:0]   pcInc;
   logic [PC_WIDTH-1:0]   brTarget;

   pc_target_calc #(
      .PC_WIDTH (PC_WIDTH)
   ) u_pc_target_calc (
      .pc_i     (pc_q),
      .pc_out_i (pcOut_q),
      .offset_i (branch_offset),
      .pc_inc_o (pcInc),
      .target_o (brTarget)
   );

   // While a killed request is in flight the address must stay on the old
   // word, so it comes from holdAddr_q rather than the already-redirected PC.
   // The request is gated by rst_n so it drops the instant reset asserts.
   assign imem_req    = rst_n && (state_q == FETCH);
   assign imem_addr   = kill_q ? holdAddr_q : pc_q;
   assign instruction = inst_q;
   assign inst_valid  = valid_q;
   assign pc_out      = pcOut_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= FETCH;
         pc_q       <= RESET_PC;
         pcOut_q    <= '0;
         holdAddr_q <= '0;
         inst_q     <= '0;
         valid_q    <= 1'b0;
         kill_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pcOut_q    <= pcOut_d;
         holdAddr_q <= holdAddr_d;
         inst_q     <= inst_d;
         valid_q    <= valid_d;
         kill_q     <= kill_d;
      end
   end

   // A branch always retargets the PC; what else happens depends on whether
   // a response is arriving now, still outstanding, or already presented.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pcOut_d    = pcOut_q;
      holdAddr_d = holdAddr_q;
      inst_d     = inst_q;
      valid_d    = valid_q;
      kill_d     = kill_q;

      unique case (state_q)
         FETCH: begin
            if (imem_ack) begin
               if (kill_q || branch_taken) begin
                  kill_d = 1'b0;
                  if (branch_taken) begin
                     pc_d = brTarget;
                  end
               end else begin
                  inst_d  = imem_rdata;
                  pcOut_d = pc_q;
                  pc_d    = pcInc;
                  valid_d = 1'b1;
                  state_d = ISSUE;
               end
            end else if (branch_taken) begin
               pc_d       = brTarget;
               kill_d     = 1'b1;
               holdAddr_d = imem_addr;
            end
         end
         ISSUE: begin
            if (branch_taken) begin
               pc_d    = brTarget;
               valid_d = 1'b0;
               state_d = FETCH;
            end else if (!stall) begin
               valid_d = 1'b0;
               state_d = FETCH;
            end
         end
      endcase
   end

endmodule
